// File: rtl/bcd_pkg.sv
// Shared constants, state type and digit-validity helper for the serial BCD adder.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add with decimal correction: sums above nine get +6 and a carry.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] x,
    input  logic [BCD_DIGIT_W-1:0] y,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] raw;
    logic [BCD_DIGIT_W:0] corr;

    assign raw   = {1'b0, x} + {1'b0, y} + {{BCD_DIGIT_W{1'b0}}, cin};
    assign corr  = raw + {1'b0, BCD_CORR};
    assign cout  = (raw > {1'b0, BCD_MAX});
    assign digit = cout ? corr[BCD_DIGIT_W-1:0] : raw[BCD_DIGIT_W-1:0];

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder: one digit per clock, LSD first, with a start/busy/done handshake.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    output logic                        busy,
    output logic                        done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                        cout,
    output logic                        err
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SLOTS = 1 << IW;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            cout_q, cout_d, err_q, err_d, done_q, done_d;

    logic [BCD_DIGIT_W-1:0] a_slot [SLOTS];
    logic [BCD_DIGIT_W-1:0] b_slot [SLOTS];
    logic [2*DIGITS-1:0]    bad_digit;
    logic [BCD_DIGIT_W-1:0] dig_sum;
    logic                   dig_carry;

    // Pad the digit mux to a power of two so any idx value selects a defined slot.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < DIGITS) begin : g_real
                assign a_slot[gi] = a_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
                assign b_slot[gi] = b_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
                assign bad_digit[2*gi]   = !is_bcd_digit(a[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
                assign bad_digit[2*gi+1] = !is_bcd_digit(b[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
            end else begin : g_pad
                assign a_slot[gi] = '0;
                assign b_slot[gi] = '0;
            end
        end
    endgenerate

    bcd_digit_add u_digit (
        .x     (a_slot[idx_q]),
        .y     (b_slot[idx_q]),
        .cin   (carry_q),
        .digit (dig_sum),
        .cout  (dig_carry)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    carry_d = 1'b0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                    err_d   = |bad_digit;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) begin
                        sum_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dig_sum;
                    end
                end
                carry_d = dig_carry;
                if (idx_q == LAST_IDX) begin
                    cout_d  = dig_carry;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: transaction-level decimal model, per-cycle compare, directed vectors.
module tb_bcd_serial_adder;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    logic         start2;
    logic [3:0]   a2, b2;
    logic         busy2, done2, cout2, err2;
    logic [3:0]   sum2;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    bit           m_busy = 1'b0;
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_sum  = '0;
    logic [W-1:0] p_sum  = '0;
    bit           m_cout = 1'b0;
    bit           p_cout = 1'b0;
    bit           m_err  = 1'b0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    bcd_serial_adder #(.DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .err(err2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit any_bad(input logic [W-1:0] x, input logic [W-1:0] y);
        bit r = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (x[i*4 +: 4] > 4'd9 || y[i*4 +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    // Valid operands go through plain decimal integers; invalid ones use the digit rule.
    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y);
        int           dx = 0;
        int           dy = 0;
        int           tot;
        int           t;
        logic [W-1:0] s = '0;
        logic         c = 1'b0;
        if (!any_bad(x, y)) begin
            for (int i = D - 1; i >= 0; i--) begin
                dx = dx * 10 + int'(x[i*4 +: 4]);
                dy = dy * 10 + int'(y[i*4 +: 4]);
            end
            tot = dx + dy;
            for (int i = 0; i < D; i++) begin
                s[i*4 +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
            c = (tot != 0);
        end else begin
            for (int i = 0; i < D; i++) begin
                t = int'(x[i*4 +: 4]) + int'(y[i*4 +: 4]) + int'(c);
                if (t > 9) begin
                    t = t + 6;
                    c = 1'b1;
                end else begin
                    c = 1'b0;
                end
                s[i*4 +: 4] = 4'(t % 16);
            end
        end
        return {c, s};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_left = 0; m_done = 1'b0;
            m_sum = '0; m_cout = 1'b0; m_err = 1'b0;
            p_sum = '0; p_cout = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start === 1'b1) begin
                    m_busy = 1'b1;
                    m_left = D;
                    {p_cout, p_sum} = model_add(a, b);
                    m_err  = any_bad(a, b);
                    m_sum  = '0;
                    m_cout = 1'b0;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_sum  = p_sum;
                    m_cout = p_cout;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("cyc_busy", busy, m_busy);
            chk("cyc_done", done, m_done);
            chk("cyc_err", err, m_err);
            if (!m_busy) begin
                chk("cyc_sum", sum, m_sum);
                chk("cyc_cout", cout, m_cout);
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done !== 1'b1 && n < 50);
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout actual=no_done required=done_within_50");
        end
    endtask

    task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] esum, input logic ecout, input logic eerr);
        int n;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        chk("run_busy", busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        wait_done(n);
        chk("run_lat", n, D);
        chk("run_sum", sum, esum);
        chk("run_cout", cout, ecout);
        chk("run_err", err, eerr);
        $display("txn a=%h b=%h sum=%h cout=%0d err=%0d lat=%0d", av, bv, sum, cout, err, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        chk("pin_1234", model_add(16'h1234, 16'h5678), 17'h06912);
        chk("pin_9999", model_add(16'h9999, 16'h0001), 17'h10000);
        chk("pin_00A1", model_add(16'h00A1, 16'h0001), 17'h00102);
        chk("pin_0005", model_add(16'h0005, 16'h0005), 17'h00010);

        // Reset dropped mid-run, off the clock edge
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_sum", sum, 16'h0000);
        chk("arst_cout", cout, 1'b0);
        chk("arst_err", err, 1'b0);
        $display("txn async_reset busy=%0d done=%0d sum=%h", busy, done, sum);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", busy, 1'b0);

        run(16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0);
        run(16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // start held during the run, then relaunch inside the done cycle
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("hold_lat", n, D - 2);
        chk("hold_sum", sum, 16'h6912);
        $display("txn hold a=1234 b=5678 sum=%h lat=%0d", sum, n);
        @(negedge clk);
        a = 16'h0005; b = 16'h0005; start = 1'b1;
        @(posedge clk);
        #1;
        chk("relaunch_busy", busy, 1'b1);
        chk("relaunch_done", done, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("relaunch_lat", n, D);
        chk("relaunch_sum", sum, 16'h0010);
        chk("relaunch_cout", cout, 1'b0);
        $display("txn relaunch a=0005 b=0005 sum=%h lat=%0d", sum, n);

        run(16'h00A1, 16'h0001, 16'h0102, 1'b0, 1'b1);
        chk("inv_lsd", sum[3:0], 4'd2);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("inv_err_hold", err, 1'b1);
            chk("inv_sum_hold", sum, 16'h0102);
        end
        run(16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

        // Single-digit instance
        @(negedge clk);
        a2 = 4'h8; b2 = 4'h7; start2 = 1'b1;
        @(posedge clk);
        #1;
        chk("d1_busy", busy2, 1'b1);
        @(negedge clk);
        start2 = 1'b0;
        @(posedge clk);
        #1;
        chk("d1_done", done2, 1'b1);
        chk("d1_sum", sum2, 4'h5);
        chk("d1_cout", cout2, 1'b1);
        chk("d1_err", err2, 1'b0);
        $display("txn d1 a=8 b=7 sum=%h cout=%0d", sum2, cout2);
        @(posedge clk);
        #1;
        chk("d1_done_pulse", done2, 1'b0);
        chk("d1_idle", busy2, 1'b0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
